regfile32: RTL and testbench

REGFILE32 -- requirements
Module: regfile32

---
 rtl/regfile32.sv | 80 ++++++++
 tb/tb_regfile32.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regfile32.sv
// 32-entry register file: one write port, two combinational read ports with
// optional same-cycle write forwarding, plus a saturating commit counter.

module regfile32_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (we)   q <= d;
  end
endmodule

module regfile32 #(
  parameter int WIDTH  = 32,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             RegWrite,
  input  logic [4:0]       WriteReg,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadReg1,
  input  logic [4:0]       ReadReg2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2,
  output logic [15:0]      WriteCount
);
  logic [31:0]            we;
  logic [31:0][WIDTH-1:0] r;
  logic [1:0][4:0]        ra;
  logic [1:0][WIDTH-1:0]  rd;
  logic                   commit;

  // One-hot write enable; bit 0 is forced low so R0 never loads and never
  // participates in forwarding.
  always_comb begin
    we = '0;
    if (RegWrite) we[WriteReg] = 1'b1;
    we[0] = 1'b0;
  end

  assign commit = |we;
  assign r[0]   = '0;

  for (genvar i = 1; i < 32; i++) begin : g_reg
    regfile32_cell #(.WIDTH(WIDTH)) u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (we[i]),
      .d       (WriteData),
      .q       (r[i])
    );
  end

  assign ra = {ReadReg2, ReadReg1};

  // Reset forces zero even on a forwarded hit, so nothing leaks while held.
  always_comb begin
    rd = '0;
    for (int p = 0; p < 2; p++) begin
      rd[p] = r[ra[p]];
      if (BYPASS != 0 && we[ra[p]]) rd[p] = WriteData;
      if (!reset_n) rd[p] = '0;
    end
  end

  assign ReadData1 = rd[0];
  assign ReadData2 = rd[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          WriteCount <= '0;
    else if (commit && WriteCount != '1)   WriteCount <= WriteCount + 16'd1;
  end
endmodule

// File: tb/tb_regfile32.sv
// Self-checking bench for regfile32: table vectors, reset corner sequences,
// randomized traffic against an array model, and counter saturation.

module tb_regfile32;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        RegWrite;
  logic [4:0]  WriteReg, ReadReg1, ReadReg2;
  logic [31:0] WriteData;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic [15:0] cnt_b, cnt_n;

  int total = 0;
  int bad   = 0;

  logic [31:0] m [32];
  int unsigned mcnt;

  always #5 clk = ~clk;

  regfile32 #(.WIDTH(32), .BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(rd1_b), .ReadData2(rd2_b), .WriteCount(cnt_b)
  );

  regfile32 #(.WIDTH(32), .BYPASS(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(rd1_n), .ReadData2(rd2_n), .WriteCount(cnt_n)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a1, a2;
    logic [31:0] e1, e2;   // pre-edge outputs of the forwarding instance
    logic [15:0] ecnt;     // count after the edge
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = '0;
    mcnt = 0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit fwd);
    if (!reset_n) return '0;
    if (fwd && RegWrite && WriteReg != 0 && a == WriteReg) return WriteData;
    return m[a];
  endfunction

  task automatic check_reads(input string tag);
    chk({tag, ".b1"}, rd1_b, exp_rd(ReadReg1, 1'b1));
    chk({tag, ".b2"}, rd2_b, exp_rd(ReadReg2, 1'b1));
    chk({tag, ".n1"}, rd1_n, exp_rd(ReadReg1, 1'b0));
    chk({tag, ".n2"}, rd2_n, exp_rd(ReadReg2, 1'b0));
  endtask

  task automatic check_cnt(input string tag);
    chk({tag, ".cnt_b"}, {16'd0, cnt_b}, mcnt);
    chk({tag, ".cnt_n"}, {16'd0, cnt_n}, mcnt);
  endtask

  // Advance one rising edge, update the model from the driven inputs,
  // and return at the following falling edge.
  task automatic edge_();
    @(posedge clk);
    if (reset_n && RegWrite && WriteReg != 0) begin
      m[WriteReg] = WriteData;
      if (mcnt != 32'hFFFF) mcnt++;
    end
    @(negedge clk);
  endtask

  vec_t vt [9];

  initial begin
    vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5, 5'd0,  32'hDEADBEEF, 32'h0,        16'd1};
    vt[1] = '{1'b1, 5'd31, 32'h12345678, 5'd5, 5'd31, 32'hDEADBEEF, 32'h12345678, 16'd2};
    vt[2] = '{1'b0, 5'd0,  32'h0,        5'd5, 5'd31, 32'hDEADBEEF, 32'h12345678, 16'd2};
    vt[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd0,  32'h0,        32'h0,        16'd2};
    vt[4] = '{1'b0, 5'd9,  32'h1,        5'd9, 5'd9,  32'h0,        32'h0,        16'd2};
    vt[5] = '{1'b0, 5'd9,  32'h1,        5'd9, 5'd5,  32'h0,        32'hDEADBEEF, 16'd2};
    vt[6] = '{1'b0, 5'd9,  32'h1,        5'd9, 5'd9,  32'h0,        32'h0,        16'd2};
    vt[7] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7, 5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 16'd3};
    vt[8] = '{1'b0, 5'd7,  32'h0,        5'd7, 5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 16'd3};

    reset_n = 1'b0; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg1 = '0; ReadReg2 = '0;
    model_reset();

    // Reset: every index reads zero even with a forwarding-eligible write driven.
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i);
      RegWrite = 1'b1; WriteReg = 5'(i); WriteData = $urandom;
      #1;
      check_reads("rst_read");
    end
    check_cnt("rst");
    RegWrite = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_reads("post_rel");

    // Table vectors
    for (int v = 0; v < 9; v++) begin
      RegWrite = vt[v].we; WriteReg = vt[v].wa; WriteData = vt[v].wd;
      ReadReg1 = vt[v].a1; ReadReg2 = vt[v].a2;
      #1;
      chk($sformatf("tbl%0d.rd1", v), rd1_b, vt[v].e1);
      chk($sformatf("tbl%0d.rd2", v), rd2_b, vt[v].e2);
      check_reads($sformatf("tbl%0d", v));
      edge_();
      chk($sformatf("tbl%0d.cnt", v), {16'd0, cnt_b}, {16'd0, vt[v].ecnt});
      check_cnt($sformatf("tbl%0d", v));
    end
    // Non-forwarding instance sees the new R7 only after the edge.
    chk("nobyp_r7_post", rd1_n, 32'hA5A5A5A5);

    // Reset mid-operation between edges, then a write held across a reset edge.
    RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h55;
    edge_();
    RegWrite = 1'b0; ReadReg1 = 5'd3; ReadReg2 = 5'd3;
    #1;
    chk("r3_written", rd1_b, 32'h55);
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("r3_reset_b", rd1_b, 32'h0);
    chk("r3_reset_n", rd2_n, 32'h0);
    check_cnt("midrst");
    RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h77;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1; RegWrite = 1'b0;
    #1;
    chk("discard_r3", rd1_b, 32'h0);
    check_cnt("discard");
    RegWrite = 1'b1; WriteReg = 5'd12; WriteData = 32'h99; ReadReg1 = 5'd12;
    edge_();
    RegWrite = 1'b0;
    #1;
    chk("first_after_rst", rd1_b, 32'h99);
    chk("first_cnt", {16'd0, cnt_b}, 32'd1);
    check_cnt("first");

    // Randomized traffic against the array model.
    for (int n = 0; n < 400; n++) begin
      RegWrite  = ($urandom_range(0, 3) != 0);
      WriteReg  = 5'($urandom_range(0, 31));
      WriteData = $urandom;
      ReadReg1  = ($urandom_range(0, 2) == 0) ? WriteReg : 5'($urandom_range(0, 31));
      ReadReg2  = ($urandom_range(0, 3) == 0) ? ReadReg1 : 5'($urandom_range(0, 31));
      #1;
      check_reads("rnd");
      if (ReadReg1 == ReadReg2) chk("rnd_same_idx", rd2_b, rd1_b);
      edge_();
      check_cnt("rnd");
    end

    // Counter saturation.
    reset_n = 1'b0;
    model_reset();
    #1;
    reset_n = 1'b1;
    RegWrite = 1'b1;
    for (int n = 1; n <= 65537; n++) begin
      WriteReg = 5'($urandom_range(1, 31)); WriteData = $urandom;
      edge_();
      if (n == 65534 || n == 65535 || n == 65537) check_cnt($sformatf("sat%0d", n));
    end
    chk("sat_final", {16'd0, cnt_b}, 32'h0000FFFF);
    RegWrite = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
